apb_request_arbiter: RTL

Round-robin arbiter that shares the single APB master between `NUM_REQ` CPU-side requesters. It accepts per-requester transfer requests (slave select, address, write data) and grants one at a time. It launches the master with a one-cycle `APBMASTERENABLE` pulse, waits for `CPUPREADY`, and returns a done/error pulse to the granted requester. It sits between the CPU request fabric and the APB master, directly driving the master's CPU-side inputs.

---
 rtl/apb_request_arbiter_pkg.sv | 18 +
 rtl/apb_request_arbiter_if.sv | 34 +++
 rtl/apb_request_arbiter_rr_picker.sv | 33 +++
 rtl/apb_request_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/apb_request_arbiter_pkg.sv
// Shared types and default widths for the APB request arbiter.
//   arb_state_t : arbiter FSM state encoding
//   SEL_W, ADDR_W, DATA_W : default payload widths toward the APB master
package apb_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StRelease
  } arb_state_t;

  localparam int unsigned SEL_W  = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 21;

endpackage

// File: rtl/apb_request_arbiter_if.sv
// Bundle of requester-side and APB-master-side signals of the arbiter.
//   slave  : arbiter view (takes requests and CPUPREADY, drives grant/done/master inputs)
//   master : environment view (requesters plus the APB master)
interface apb_request_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SEL_W   = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 21
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*SEL_W-1:0]  req_sel;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        req_done;
  logic                      req_error;
  logic                      APBMASTERENABLE;
  logic [SEL_W-1:0]          CPUSEL;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_data;
  logic                      CPUPREADY;

  modport slave (
    input  req_valid, req_sel, req_addr, req_data, CPUPREADY,
    output req_grant, req_done, req_error, APBMASTERENABLE, CPUSEL, m_addr, m_data
  );

  modport master (
    output req_valid, req_sel, req_addr, req_data, CPUPREADY,
    input  req_grant, req_done, req_error, APBMASTERENABLE, CPUSEL, m_addr, m_data
  );

endinterface

// File: rtl/apb_request_arbiter_rr_picker.sv
// Combinational round-robin search.
//   req     : per-requester request levels
//   ptr     : index where the search starts (wraps around)
//   win     : one-hot winner (all zero when no request)
//   win_idx : binary index of the winner (0 when no request)
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IdxW-1:0]    win_idx
);

  always_comb begin
    logic        found;
    int unsigned idx;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (!found && req[idx[IdxW-1:0]]) begin
        found                 = 1'b1;
        win[idx[IdxW-1:0]]    = 1'b1;
        win_idx               = idx[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ requesters.
//   clk     : system clock, rising edge
//   PRESETn : asynchronous active-low reset
//   bus     : requester side (req_valid/sel/addr/data in, req_grant/done/error out)
//             and master side (APBMASTERENABLE/CPUSEL/m_addr/m_data out, CPUPREADY in)
// Every output comes straight from a flop.
module apb_request_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SEL_W   = apb_arb_pkg::SEL_W,
  parameter int unsigned ADDR_W  = apb_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W  = apb_arb_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 PRESETn,
  apb_request_arbiter_if.slave bus
);

  import apb_arb_pkg::*;

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                en_q, en_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [NUM_REQ-1:0]  win;
  logic [IdxW-1:0]     win_idx;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IdxW   (IdxW)
  ) u_picker (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .win    (win),
    .win_idx(win_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    grant_d = grant_q;
    done_d  = '0;
    en_d    = 1'b0;
    sel_d   = sel_q;
    addr_d  = addr_q;
    data_d  = data_q;

    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          state_d = StIssue;
          grant_d = win;
          en_d    = 1'b1;
          // Payload is frozen here; later req_* changes are ignored.
          sel_d   = bus.req_sel[win_idx*SEL_W +: SEL_W];
          addr_d  = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
          data_d  = bus.req_data[win_idx*DATA_W +: DATA_W];
          ptr_d   = IdxW'((32'(win_idx) + 1) % NUM_REQ);
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Ready takes priority over an expiring timeout.
        if (bus.CPUPREADY) begin
          state_d = StDone;
          done_d  = grant_q;
          grant_d = '0;
          err_d   = 1'b0;
        end else if (cnt_q == CntMax) begin
          state_d = StDone;
          done_d  = grant_q;
          grant_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        err_d   = 1'b0;
        // A ready still high here belongs to the finished transfer.
        state_d = bus.CPUPREADY ? StRelease : StIdle;
      end
      StRelease: begin
        if (!bus.CPUPREADY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      en_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.req_grant       = grant_q;
  assign bus.req_done        = done_q;
  assign bus.req_error       = err_q;
  assign bus.APBMASTERENABLE = en_q;
  assign bus.CPUSEL          = sel_q;
  assign bus.m_addr          = addr_q;
  assign bus.m_data          = data_q;

endmodule
